sdram_req_queue: RTL and testbench
==================================

Name: sdram_req_queue

Overview:
- Client-side command queue feeding one sub port of the SDRAM arbiter, on the manager side of an sdram_ctrl_if-style link.
- Buffers client read/write requests in a FIFO and issues them one at a time with the rd/wr/rdy strobe handshake.
- Waits for rvalid/wvalid/error, then returns one response per request on a valid/ready response channel.
- Guards against lost completions with a per-request timeout.

Parameters:
- ADDR_W, 24, address width.
- DATA_W, 32, data width; byte-enable width BE_W = DATA_W/8.
- DEPTH, 4, request FIFO entries; power of 2, ≥2.
- TIMEOUT, 1023, max WAIT cycles before error response; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  client request valid
- req_ready  out  1  FIFO can accept (= !full)
- req_we  in  1  1=write, 0=read
- req_be  in  BE_W  write byte enables; ignored for reads
- req_addr  in  ADDR_W  request address
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  response valid
- rsp_ready  in  1  client accepts response
- rsp_data  out  DATA_W  read data (0 for writes and errors without rvalid)
- rsp_write  out  1  response belongs to a write
- rsp_err  out  1  controller error, timeout, or zero-BE write
- level  out  $clog2(DEPTH+1)  FIFO occupancy
- mem_rd  out  1  read strobe to arbiter
- mem_wr  out  BE_W  write byte-mask strobe to arbiter
- mem_addr  out  ADDR_W  address to arbiter
- mem_write_data  out  DATA_W  write data to arbiter
- mem_rdy  in  1  arbiter grants the strobe this cycle
- mem_rvalid  in  1  read completion
- mem_wvalid  in  1  write completion
- mem_error  in  1  controller error
- mem_read_data  in  DATA_W  read data, valid with mem_rvalid

Behaviour:
- Reset: FIFO emptied, level=0, req_ready=1 from the first cycle after reset, state=IDLE. Outputs rsp_valid, rsp_data, rsp_write, rsp_err, mem_rd, mem_wr, mem_addr and mem_write_data are all 0.
- FIFO push: on req_valid & req_ready.
- FIFO pop: only in IDLE.
- Simultaneous push and pop: level unchanged.
- No push when full; no pop when empty.
- Write pointer and read pointer wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if level≠0, pop the head into the command register.
  - Write with req_be==0: go to RESP with rsp_err=1, rsp_write=1, rsp_data=0; no mem strobe.
  - Otherwise: go to ISSUE.
- ISSUE: drive the command from registers.
  - Read: mem_rd=1, mem_wr=0.
  - Write: mem_wr=be, mem_rd=0.
  - mem_addr and mem_write_data are held stable.
  - On mem_rdy=1 in a cycle with a strobe asserted: go to WAIT. Strobes, addr and data are 0 from the next cycle.
  - Stall indefinitely while mem_rdy=0; no timeout in ISSUE.
- WAIT: timeout counter cleared on entry and incremented each cycle.
  - On mem_rvalid|mem_wvalid|mem_error: capture rsp_data=mem_read_data if mem_rvalid else 0, and rsp_err=mem_error; go to RESP.
  - mem_error together with mem_rvalid: rsp_err=1 and data still captured.
  - When TIMEOUT≠0 and the counter reaches TIMEOUT with no completion: rsp_err=1, rsp_data=0, go to RESP.
- RESP: rsp_valid=1; rsp_* held stable until rsp_ready. On rsp_valid & rsp_ready, go to IDLE.
- Outstanding operations: at most one.
- Response ordering: responses return in request order.
- Completion inputs (rvalid/wvalid/error) outside WAIT are ignored, including late completions after a timeout.
- Latency:
  - Request accepted in cycle N into an empty FIFO with FSM IDLE: pop in N+1, strobe first asserted in N+2.
  - Completion sampled in cycle M: rsp_valid=1 in M+1.
  - rsp handshake in cycle K: next pop at K+1 at the earliest.
- Reset mid-operation: the in-flight command and queued requests are discarded, and strobes drop in the cycle after reset.

Test Plan:
- Single read: push read addr 0x000100, mem_rdy=1 immediately, mem_rvalid with data 0xDEADBEEF 3 cycles later → mem_rd high exactly 1 cycle at N+2; rsp_valid, rsp_data=0xDEADBEEF, rsp_err=0, rsp_write=0.
- Back-pressure and full: push 5 requests with mem_rdy=0 (DEPTH=4) → first popped; pushes 2–5 fill the FIFO and req_ready=0 with level=4. Then release mem_rdy → all 5 are issued in order and 5 in-order responses return.
- Write with rdy stall: write be=0b0011, data 0x12345678, mem_rdy low 6 cycles → mem_wr=0011 and data stable for all 7 cycles. After wvalid: rsp_write=1, rsp_err=0.
- Zero-BE write: push write be=0 → no mem strobe ever; response rsp_err=1, rsp_write=1, rsp_data=0.
- Timeout: TIMEOUT=8, read granted, no completion → rsp_err=1 after 8 WAIT cycles. A late mem_rvalid then produces no response, and the next queued read completes normally.
- Response stall and reset: hold rsp_ready=0 for 10 cycles → rsp_* stable and no new mem strobe. Then assert rst while in WAIT with 2 queued → level=0, rsp_valid=0, mem_rd=0, and the following rvalid is ignored.

Source files
------------

// File: rtl/sdram_req_queue.sv
// rtl/sdram_req_queue.sv - client request FIFO issuing one SDRAM command at a time with timeout-guarded responses
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   req_valid/req_ready/req_we/
//   req_be/req_addr/req_wdata        client request channel into the FIFO
//   rsp_valid/rsp_ready/rsp_data/
//   rsp_write/rsp_err                in-order response channel back to the client
//   level                            FIFO occupancy
//   mem_rd/mem_wr/mem_addr/
//   mem_write_data/mem_rdy           strobe handshake toward the arbiter sub port
//   mem_rvalid/mem_wvalid/mem_error/
//   mem_read_data                    completion inputs from the controller
module sdram_req_queue #(
    parameter int ADDR_W  = 24,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1023,
    localparam int BE_W   = DATA_W / 8,
    localparam int LVL_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [BE_W-1:0]   req_be,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_write,
    output logic              rsp_err,
    output logic [LVL_W-1:0]  level,
    output logic              mem_rd,
    output logic [BE_W-1:0]   mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic              mem_rdy,
    input  logic              mem_rvalid,
    input  logic              mem_wvalid,
    input  logic              mem_error,
    input  logic [DATA_W-1:0] mem_read_data
);

    localparam int PTR_W = $clog2(DEPTH);
    // The wait counter only ever needs to hold 0..TIMEOUT-1.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef struct packed {
        logic              we;
        logic [BE_W-1:0]   be;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t state, state_next;

    cmd_t             fifo_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] count;
    logic             full;
    logic             push;
    logic             pop;
    cmd_t             head;
    cmd_t             cmd;
    logic [CNT_W-1:0] wait_cnt;
    logic             done;
    logic             timed_out;
    logic             head_zero_be;

    assign full         = (count == LVL_W'(DEPTH));
    assign req_ready    = !full;
    assign level        = count;
    assign push         = req_valid && !full;
    assign pop          = (state == S_IDLE) && (count != '0);
    assign head         = fifo_mem[rd_ptr];
    assign head_zero_be = head.we && (head.be == '0);
    assign done         = mem_rvalid || mem_wvalid || mem_error;
    assign timed_out    = (TIMEOUT != 0) && (wait_cnt == CNT_LAST);

    // Storage needs no reset; only pointers and count define contents.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{we: req_we, be: req_be, addr: req_addr, wdata: req_wdata};
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: begin
                if (count != '0) begin
                    // A write with no enabled bytes is answered locally as an error.
                    state_next = head_zero_be ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                // A strobe is always asserted here, so a grant alone moves on.
                if (mem_rdy) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (done || timed_out) begin
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd       <= '0;
            rsp_data  <= '0;
            rsp_write <= 1'b0;
            rsp_err   <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (pop) begin
                        cmd       <= head;
                        rsp_write <= head.we;
                        rsp_err   <= head_zero_be;
                        rsp_data  <= '0;
                    end
                end
                S_ISSUE: begin
                    wait_cnt <= '0;
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    // A real completion in the last counted cycle wins over the timeout.
                    if (done) begin
                        rsp_data <= mem_rvalid ? mem_read_data : '0;
                        rsp_err  <= mem_error;
                    end else if (timed_out) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Arbiter-facing outputs are decoded from state so they fall to zero
    // the cycle after a grant or a reset.
    assign rsp_valid      = (state == S_RESP);
    assign mem_rd         = (state == S_ISSUE) && !cmd.we;
    assign mem_wr         = ((state == S_ISSUE) && cmd.we) ? cmd.be : '0;
    assign mem_addr       = (state == S_ISSUE) ? cmd.addr : '0;
    assign mem_write_data = ((state == S_ISSUE) && cmd.we) ? cmd.wdata : '0;

endmodule

// File: tb/tb_sdram_req_queue.sv
// tb/tb_sdram_req_queue.sv - self-checking bench for sdram_req_queue
module tb_sdram_req_queue;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [3:0]  req_be;
    logic [23:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_write;
    logic        rsp_err;
    logic [2:0]  level;
    logic        mem_rd;
    logic [3:0]  mem_wr;
    logic [23:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        mem_rdy;
    logic        mem_rvalid;
    logic        mem_wvalid;
    logic        mem_error;
    logic [31:0] mem_read_data;

    int checks = 0;
    int errors = 0;

    sdram_req_queue #(
        .ADDR_W (24),
        .DATA_W (32),
        .DEPTH  (4),
        .TIMEOUT(8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_be        (req_be),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_write     (rsp_write),
        .rsp_err       (rsp_err),
        .level         (level),
        .mem_rd        (mem_rd),
        .mem_wr        (mem_wr),
        .mem_addr      (mem_addr),
        .mem_write_data(mem_write_data),
        .mem_rdy       (mem_rdy),
        .mem_rvalid    (mem_rvalid),
        .mem_wvalid    (mem_wvalid),
        .mem_error     (mem_error),
        .mem_read_data (mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid     = 1'b0;
        req_we        = 1'b0;
        req_be        = 4'h0;
        req_addr      = 24'h0;
        req_wdata     = 32'h0;
        rsp_ready     = 1'b0;
        mem_rdy       = 1'b0;
        mem_rvalid    = 1'b0;
        mem_wvalid    = 1'b0;
        mem_error     = 1'b0;
        mem_read_data = 32'h0;
    endtask

    // ---------------- reference model for randomized traffic ----------------
    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [23:0] addr;
        logic [31:0] wdata;
    } req_t;

    req_t        pend[$];   // every accepted request, awaiting its response
    req_t        iss[$];    // accepted requests that must reach the arbiter
    int          resp_wait = -1;
    logic        resp_we;
    logic [23:0] resp_addr;
    int          rsp_cnt = 0;
    bit          force_read = 1'b0;

    function automatic logic [31:0] mem_fn(input logic [23:0] a);
        return {a[7:0], a} ^ 32'h5A00_0000;
    endfunction

    function automatic logic addr_err(input logic [23:0] a);
        return a[3:0] == 4'hF;
    endfunction

    function automatic logic [31:0] exp_data(input req_t r);
        if (r.we) return 32'h0;
        if (addr_err(r.addr) && !r.addr[4]) return 32'h0;
        return mem_fn(r.addr);
    endfunction

    function automatic logic exp_err(input req_t r);
        return (r.we && r.be == 4'h0) || addr_err(r.addr);
    endfunction

    task automatic model_clear();
        pend.delete();
        iss.delete();
        resp_wait = -1;
    endtask

    task automatic eng_cycle(input int req_pct, input int rdy_pct, input int rsp_pct);
        req_t r;
        req_t h;
        mem_rvalid    = 1'b0;
        mem_wvalid    = 1'b0;
        mem_error     = 1'b0;
        mem_read_data = 32'h0;
        if (resp_wait == 0) begin
            if (addr_err(resp_addr)) begin
                mem_error = 1'b1;
                if (!resp_we && resp_addr[4]) begin
                    mem_rvalid    = 1'b1;
                    mem_read_data = mem_fn(resp_addr);
                end
            end else if (resp_we) begin
                mem_wvalid = 1'b1;
            end else begin
                mem_rvalid    = 1'b1;
                mem_read_data = mem_fn(resp_addr);
            end
            resp_wait = -1;
        end else if (resp_wait > 0) begin
            resp_wait--;
        end
        mem_rdy   = ($urandom_range(0, 99) < rdy_pct);
        rsp_ready = ($urandom_range(0, 99) < rsp_pct);
        req_valid = ($urandom_range(0, 99) < req_pct);
        r.we      = force_read ? 1'b0 : 1'($urandom_range(0, 1));
        r.be      = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        r.addr    = 24'($urandom);
        r.wdata   = $urandom;
        req_we    = r.we;
        req_be    = r.be;
        req_addr  = r.addr;
        req_wdata = r.wdata;

        if (req_valid && req_ready) begin
            pend.push_back(r);
            if (!(r.we && r.be == 4'h0)) iss.push_back(r);
        end
        if ((mem_rd || mem_wr != 4'h0) && mem_rdy) begin
            check("issue_expected", 64'(iss.size() != 0), 64'(1));
            if (iss.size() != 0) begin
                h = iss.pop_front();
                check("issue_addr", 64'(mem_addr), 64'(h.addr));
                check("issue_rd", 64'(mem_rd), 64'(!h.we));
                check("issue_wr", 64'(mem_wr), 64'(h.we ? h.be : 4'h0));
                if (h.we) check("issue_wdata", 64'(mem_write_data), 64'(h.wdata));
                resp_wait = $urandom_range(0, 3);
                resp_we   = h.we;
                resp_addr = h.addr;
            end
        end
        if (rsp_valid && rsp_ready) begin
            check("rsp_expected", 64'(pend.size() != 0), 64'(1));
            if (pend.size() != 0) begin
                h = pend.pop_front();
                check("rnd_rsp_data", 64'(rsp_data), 64'(exp_data(h)));
                check("rnd_rsp_err", 64'(rsp_err), 64'(exp_err(h)));
                check("rnd_rsp_write", 64'(rsp_write), 64'(h.we));
                rsp_cnt++;
            end
        end
        step();
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        model_clear();
    endtask

    // ---------------- per-cycle vector table ----------------
    typedef struct {
        logic        req_valid;
        logic        req_we;
        logic [3:0]  req_be;
        logic [23:0] req_addr;
        logic [31:0] req_wdata;
        logic        mem_rdy;
        logic        mem_rvalid;
        logic [31:0] mem_rdata;
        logic        rsp_ready;
        logic        e_ready;
        logic [2:0]  e_level;
        logic        e_rd;
        logic [3:0]  e_wr;
        logic [23:0] e_addr;
        logic        e_rspv;
        logic [31:0] e_data;
        logic        e_err;
        logic        e_write;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int   lat;
        int   n;
        logic [31:0] held;

        // single read, then a zero-byte-enable write
        vecs[0]  = '{1'b1, 1'b0, 4'h0, 24'h000100, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0,
                     1'b1, 3'd0, 1'b0, 4'h0, 24'h0, 1'b0, 32'h0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 4'h0, 24'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0,
                     1'b1, 3'd1, 1'b0, 4'h0, 24'h0, 1'b0, 32'h0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 4'h0, 24'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0,
                     1'b1, 3'd0, 1'b1, 4'h0, 24'h000100, 1'b0, 32'h0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 4'h0, 24'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0,
                     1'b1, 3'd0, 1'b0, 4'h0, 24'h0, 1'b0, 32'h0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 4'h0, 24'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0,
                     1'b1, 3'd0, 1'b0, 4'h0, 24'h0, 1'b0, 32'h0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 4'h0, 24'h0, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0,
                     1'b1, 3'd0, 1'b0, 4'h0, 24'h0, 1'b0, 32'h0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 4'h0, 24'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1,
                     1'b1, 3'd0, 1'b0, 4'h0, 24'h0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 4'h0, 24'h000200, 32'h55, 1'b0, 1'b0, 32'h0, 1'b0,
                     1'b1, 3'd0, 1'b0, 4'h0, 24'h0, 1'b0, 32'h0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 4'h0, 24'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0,
                     1'b1, 3'd1, 1'b0, 4'h0, 24'h0, 1'b0, 32'h0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 4'h0, 24'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0,
                     1'b1, 3'd0, 1'b0, 4'h0, 24'h0, 1'b1, 32'h0, 1'b1, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 4'h0, 24'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1,
                     1'b1, 3'd0, 1'b0, 4'h0, 24'h0, 1'b1, 32'h0, 1'b1, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 4'h0, 24'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0,
                     1'b1, 3'd0, 1'b0, 4'h0, 24'h0, 1'b0, 32'h0, 1'b0, 1'b0};

        // reset state
        do_reset();
        check("reset_ready", 64'(req_ready), 64'(1));
        check("reset_level", 64'(level), 64'(0));
        check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        check("reset_rsp_fields", 64'({rsp_data, rsp_write, rsp_err}), 64'(0));
        check("reset_mem_out", 64'({mem_rd, mem_wr, mem_addr}), 64'(0));
        check("reset_mem_wdata", 64'(mem_write_data), 64'(0));

        // table-driven single read and zero-BE write
        for (int i = 0; i < 12; i++) begin
            check($sformatf("v%0d_ready", i), 64'(req_ready), 64'(vecs[i].e_ready));
            check($sformatf("v%0d_level", i), 64'(level), 64'(vecs[i].e_level));
            check($sformatf("v%0d_mem_rd", i), 64'(mem_rd), 64'(vecs[i].e_rd));
            check($sformatf("v%0d_mem_wr", i), 64'(mem_wr), 64'(vecs[i].e_wr));
            check($sformatf("v%0d_mem_addr", i), 64'(mem_addr), 64'(vecs[i].e_addr));
            check($sformatf("v%0d_rsp_valid", i), 64'(rsp_valid), 64'(vecs[i].e_rspv));
            if (vecs[i].e_rspv) begin
                check($sformatf("v%0d_rsp_data", i), 64'(rsp_data), 64'(vecs[i].e_data));
                check($sformatf("v%0d_rsp_err", i), 64'(rsp_err), 64'(vecs[i].e_err));
                check($sformatf("v%0d_rsp_write", i), 64'(rsp_write), 64'(vecs[i].e_write));
            end
            req_valid     = vecs[i].req_valid;
            req_we        = vecs[i].req_we;
            req_be        = vecs[i].req_be;
            req_addr      = vecs[i].req_addr;
            req_wdata     = vecs[i].req_wdata;
            mem_rdy       = vecs[i].mem_rdy;
            mem_rvalid    = vecs[i].mem_rvalid;
            mem_read_data = vecs[i].mem_rdata;
            rsp_ready     = vecs[i].rsp_ready;
            step();
        end
        idle_inputs();

        // write held through a 6-cycle grant stall
        do_reset();
        req_valid = 1'b1; req_we = 1'b1; req_be = 4'b0011;
        req_addr = 24'h000040; req_wdata = 32'h12345678;
        step();
        idle_inputs();
        step();
        for (int i = 0; i < 7; i++) begin
            check("stall_mem_wr", 64'(mem_wr), 64'(4'b0011));
            check("stall_mem_wdata", 64'(mem_write_data), 64'(32'h12345678));
            check("stall_mem_addr", 64'(mem_addr), 64'(24'h000040));
            check("stall_mem_rd", 64'(mem_rd), 64'(0));
            mem_rdy = (i == 6);
            step();
        end
        mem_rdy = 1'b0;
        check("post_grant_wr", 64'({mem_wr, mem_write_data}), 64'(0));
        mem_wvalid = 1'b1;
        step();
        mem_wvalid = 1'b0;
        check("wr_rsp_valid", 64'(rsp_valid), 64'(1));
        check("wr_rsp_write", 64'(rsp_write), 64'(1));
        check("wr_rsp_err", 64'(rsp_err), 64'(0));
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("wr_rsp_done", 64'(rsp_valid), 64'(0));

        // timeout, ignored late completion, next read normal
        do_reset();
        mem_rdy = 1'b1;
        req_valid = 1'b1; req_addr = 24'h000300;
        step();
        req_addr = 24'h000304;
        step();
        req_valid = 1'b0;
        check("to_grant_rd", 64'(mem_rd), 64'(1));
        check("to_grant_addr", 64'(mem_addr), 64'(24'h000300));
        step();
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            step();
            lat++;
        end
        check("to_wait_cycles", 64'(lat), 64'(8));
        check("to_rsp_err", 64'(rsp_err), 64'(1));
        check("to_rsp_data", 64'(rsp_data), 64'(0));
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        mem_rvalid = 1'b1; mem_read_data = 32'h00000BAD;
        check("late_no_rsp0", 64'(rsp_valid), 64'(0));
        step();
        mem_rvalid = 1'b0;
        check("late_no_rsp1", 64'(rsp_valid), 64'(0));
        check("next_rd", 64'(mem_rd), 64'(1));
        check("next_addr", 64'(mem_addr), 64'(24'h000304));
        step();
        mem_rvalid = 1'b1; mem_read_data = 32'hCAFEF00D;
        check("late_no_rsp2", 64'(rsp_valid), 64'(0));
        step();
        mem_rvalid = 1'b0;
        check("next_rsp_valid", 64'(rsp_valid), 64'(1));
        check("next_rsp_data", 64'(rsp_data), 64'(32'hCAFEF00D));
        check("next_rsp_err", 64'(rsp_err), 64'(0));
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // response stall, then reset while waiting with two queued
        do_reset();
        mem_rdy = 1'b1;
        req_valid = 1'b1; req_addr = 24'h000500;
        step();
        req_valid = 1'b0;
        step();
        step();
        mem_rvalid = 1'b1; mem_read_data = 32'h11112222;
        step();
        mem_rvalid = 1'b0;
        held = 32'h11112222;
        for (int i = 0; i < 10; i++) begin
            check("hold_rsp_valid", 64'(rsp_valid), 64'(1));
            check("hold_rsp_data", 64'(rsp_data), 64'(held));
            check("hold_no_strobe", 64'({mem_rd, mem_wr}), 64'(0));
            req_valid = (i < 3);
            req_addr  = 24'h000510 + 24'(i * 16);
            step();
        end
        req_valid = 1'b0;
        check("hold_level", 64'(level), 64'(3));
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        step();
        check("rst_seq_rd", 64'(mem_rd), 64'(1));
        check("rst_seq_addr", 64'(mem_addr), 64'(24'h000510));
        step();
        check("rst_seq_level", 64'(level), 64'(2));
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_level", 64'(level), 64'(0));
        check("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("midrst_mem_rd", 64'(mem_rd), 64'(0));
        check("midrst_ready", 64'(req_ready), 64'(1));
        mem_rvalid = 1'b1; mem_read_data = 32'h99999999;
        step();
        mem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("midrst_ignored", 64'({rsp_valid, mem_rd, level}), 64'(0));
            step();
        end
        idle_inputs();

        // back-pressure until full, then drain in order
        do_reset();
        force_read = 1'b1;
        for (int i = 0; i < 5; i++) eng_cycle(100, 0, 100);
        req_valid = 1'b0;
        force_read = 1'b0;
        check("full_level", 64'(level), 64'(4));
        check("full_ready", 64'(req_ready), 64'(0));
        check("full_stalled_rd", 64'(mem_rd), 64'(1));
        rsp_cnt = 0;
        n = 0;
        while ((pend.size() != 0 || resp_wait >= 0) && n < 200) begin
            eng_cycle(0, 100, 100);
            n++;
        end
        check("bp_rsp_count", 64'(rsp_cnt), 64'(5));

        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < 2000; i++) eng_cycle(40, 60, 70);
        n = 0;
        while ((pend.size() != 0 || resp_wait >= 0) && n < 500) begin
            eng_cycle(0, 100, 100);
            n++;
        end
        check("rnd_drained", 64'(pend.size()), 64'(0));
        check("rnd_level_end", 64'(level), 64'(0));
        idle_inputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
